// File: rtl/r_triadic_issue_if.sv
// r_triadic_issue_if: command, byte-lane and result handshake bundle for the triadic load port
interface r_triadic_issue_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [5:0]  func;
  logic [7:0]  byte_out;
  logic [3:0]  p_strobe;
  logic        half_sel;
  logic [15:0] half_in;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        busy;
  modport master (
    output cmd_valid, rs1, rs2, rd, func, half_in, res_ready,
    input  cmd_ready, byte_out, p_strobe, half_sel, res_valid, res_data, busy
  );
  modport slave (
    input  cmd_valid, rs1, rs2, rd, func, half_in, res_ready,
    output cmd_ready, byte_out, p_strobe, half_sel, res_valid, res_data, busy
  );
endinterface

// File: rtl/r_triadic_issue.sv
// r_triadic_issue: packs R-type fields, streams them as byte beats and reads the ALU result back in halves
module r_triadic_issue #(
  parameter int SETTLE_CYCLES = 2
) (
  input logic clk,
  input logic rst_n,
  r_triadic_issue_if.slave bus
);
  localparam logic [3:0] IDLE   = 4'd0;
  localparam logic [3:0] B0     = 4'd1;
  localparam logic [3:0] B1     = 4'd2;
  localparam logic [3:0] B2     = 4'd3;
  localparam logic [3:0] B3     = 4'd4;
  localparam logic [3:0] SETTLE = 4'd5;
  localparam logic [3:0] RD_LO  = 4'd6;
  localparam logic [3:0] RD_HI  = 4'd7;
  localparam logic [3:0] DONE   = 4'd8;
  logic [3:0]  state, nxt, cnt;
  logic [31:0] word, nword;
  logic        accept, beat;
  logic [1:0]  k;
  assign accept = bus.cmd_valid & bus.cmd_ready;
  assign nword  = accept ? {6'b0, bus.rs1, bus.rs2, bus.rd, 5'b0, bus.func} : word;
  // outputs are registered from the next state so they hold for the whole state cycle
  assign beat   = nxt >= B0 && nxt <= B3;
  assign k      = 2'(nxt - B0);
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:    nxt = accept ? B0 : IDLE;
      B0:      nxt = B1;
      B1:      nxt = B2;
      B2:      nxt = B3;
      B3:      nxt = SETTLE_CYCLES == 0 ? RD_LO : SETTLE;
      SETTLE:  nxt = cnt == 4'd1 ? RD_LO : SETTLE;
      RD_LO:   nxt = RD_HI;
      RD_HI:   nxt = DONE;
      DONE:    nxt = bus.res_ready ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      word          <= '0;
      cnt           <= '0;
      bus.byte_out  <= '0;
      bus.p_strobe  <= '0;
      bus.half_sel  <= 1'b1;
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      bus.busy      <= 1'b0;
      bus.cmd_ready <= 1'b1;
    end else begin
      state         <= nxt;
      word          <= nword;
      cnt           <= state == B3 ? 4'(SETTLE_CYCLES) : state == SETTLE ? cnt - 4'd1 : cnt;
      if (beat) bus.byte_out <= nword[{k, 3'b0} +: 8];
      bus.p_strobe  <= beat ? 4'b1 << k : 4'b0;
      bus.half_sel  <= nxt != RD_HI;
      bus.res_valid <= nxt == DONE;
      bus.busy      <= nxt != IDLE;
      bus.cmd_ready <= nxt == IDLE;
      if (state == RD_LO) bus.res_data[15:0] <= bus.half_in;
      if (state == RD_HI) bus.res_data[31:16] <= bus.half_in;
    end
  end
endmodule

// File: tb/tb_r_triadic_issue.sv
// tb_r_triadic_issue: directed and random commands on two instances (settle 2 and settle 0) against a cycle model
module tb_r_triadic_issue;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] lo, hi;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc[$];
  int runs = 0;
  always #5 clk = ~clk;
  r_triadic_issue_if a ();
  r_triadic_issue_if b ();
  r_triadic_issue #(.SETTLE_CYCLES(2)) dut  (.clk(clk), .rst_n(rst_n), .bus(a));
  r_triadic_issue #(.SETTLE_CYCLES(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b));
  assign a.half_in = a.half_sel ? lo : hi;
  assign b.half_in = b.half_sel ? lo : hi;
  always @(posedge clk) begin
    cyc++;
    if (rst_n && a.cmd_valid && a.cmd_ready) acc.push_back(cyc);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // c counts cycles after the accept edge; s is the settle length; last is the cycle the result is released
  task automatic check_dut(input string n, input int c, input int s, input int last,
                           input logic [31:0] w, input logic [31:0] r,
                           input logic [7:0] bo, input logic [3:0] ps, input logic hs,
                           input logic rv, input logic bz, input logic cr, input logic [31:0] rdat);
    if (c <= 4) begin
      chk({n, ".strobe"}, 32'(ps), 32'(4'b1 << (c - 1)));
      chk({n, ".byte"}, 32'(bo), 32'(w[8*(c-1) +: 8]));
    end else begin
      chk({n, ".strobe_idle"}, 32'(ps), 32'(0));
      chk({n, ".byte_hold"}, 32'(bo), 32'(w[31:24]));
    end
    chk({n, ".half_sel"}, 32'(hs), 32'(c == 6 + s ? 0 : 1));
    chk({n, ".res_valid"}, 32'(rv), 32'(c >= 7 + s && c <= last));
    chk({n, ".busy"}, 32'(bz), 32'(c <= last));
    chk({n, ".cmd_ready"}, 32'(cr), 32'(c > last));
    if (c >= 7 + s) chk({n, ".res_data"}, rdat, r);
  endtask
  task automatic reset_chk(input string n);
    chk({n, ".rst_byte"}, 32'(a.byte_out), 32'(0));
    chk({n, ".rst_strobe"}, 32'(a.p_strobe), 32'(0));
    chk({n, ".rst_half_sel"}, 32'(a.half_sel), 32'(1));
    chk({n, ".rst_valid"}, 32'(a.res_valid), 32'(0));
    chk({n, ".rst_busy"}, 32'(a.busy), 32'(0));
    chk({n, ".rst_ready"}, 32'(a.cmd_ready), 32'(1));
    chk({n, ".rst_data"}, a.res_data, 32'(0));
  endtask
  task automatic run(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d, input logic [5:0] f,
                     input logic [15:0] l, input logic [15:0] h, input int stall, input int rst_at);
    logic [31:0] w, r;
    int la;
    w = (32'(r1) << 21) + (32'(r2) << 16) + (32'(d) << 11) + 32'(f);
    r = (32'(h) << 16) + 32'(l);
    la = 9 + stall;
    runs++;
    chk("start.cmd_ready", 32'(a.cmd_ready), 32'(1));
    lo = l;
    hi = h;
    a.rs1 = r1; a.rs2 = r2; a.rd = d; a.func = f;
    b.rs1 = r1; b.rs2 = r2; b.rd = d; b.func = f;
    a.cmd_valid = 1'b1;
    b.cmd_valid = 1'b1;
    a.res_ready = stall == 0;
    b.res_ready = 1'b0;
    for (int c = 1; c <= la; c++) begin
      @(negedge clk);
      a.cmd_valid = 1'b0;
      b.cmd_valid = 1'b0;
      check_dut("s2", c, 2, la, w, r, a.byte_out, a.p_strobe, a.half_sel, a.res_valid, a.busy, a.cmd_ready, a.res_data);
      check_dut("s0", c, 0, 7, w, r, b.byte_out, b.p_strobe, b.half_sel, b.res_valid, b.busy, b.cmd_ready, b.res_data);
      if (c == rst_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        reset_chk("midop");
        rst_n = 1'b1;
        return;
      end
      if (stall >= 2 && c == 10) begin
        a.cmd_valid = 1'b1;
        a.rs1 = 5'($urandom); a.rs2 = 5'($urandom); a.rd = 5'($urandom); a.func = 6'($urandom);
      end
      if (c == la) a.res_ready = 1'b1;
      if (c == 7) b.res_ready = 1'b1;
    end
    @(negedge clk);
    check_dut("s2", la + 1, 2, la, w, r, a.byte_out, a.p_strobe, a.half_sel, a.res_valid, a.busy, a.cmd_ready, a.res_data);
    check_dut("s0", la + 1, 0, 7, w, r, b.byte_out, b.p_strobe, b.half_sel, b.res_valid, b.busy, b.cmd_ready, b.res_data);
  endtask
  initial begin
    lo = '0; hi = '0;
    a.cmd_valid = 0; a.rs1 = 0; a.rs2 = 0; a.rd = 0; a.func = 0; a.res_ready = 0;
    b.cmd_valid = 0; b.rs1 = 0; b.rs2 = 0; b.rd = 0; b.func = 0; b.res_ready = 0;
    repeat (3) @(negedge clk);
    reset_chk("init");
    rst_n = 1'b1;
    @(negedge clk);
    run(5'd3, 5'd4, 5'd5, 6'h20, 16'hBEEF, 16'hDEAD, 0, 0);
    chk("directed.word_data", a.res_data, 32'hDEADBEEF);
    run(5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom), 16'($urandom), 16'($urandom), 0, 0);
    chk("b2b_gap", 32'(acc[1] - acc[0]), 32'd10);
    run(5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom), 16'($urandom), 16'($urandom), 5, 0);
    run(5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom), 16'($urandom), 16'($urandom), 0, 3);
    run(5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom), 16'($urandom), 16'($urandom), 0, 0);
    for (int i = 0; i < 6; i++)
      run(5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom), 16'($urandom), 16'($urandom),
          int'($urandom_range(0, 3)), 0);
    chk("accept_count", 32'(acc.size()), 32'(runs));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
